// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the RV32I integer register file.
//   XLEN_DEF / NREGS_DEF / NUM_RD_DEF : default data width, register count, read ports.
//   AW_DEF                            : register address width for the defaults.
//   reg_addr_t / xword_t              : address and data word types for the defaults.
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned AW_DEF     = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bits for long-latency destinations.
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en, wr_addr    : writeback, clears the pending bit of wr_addr
//   sb_set, sb_addr   : issue, sets the pending bit of sb_addr
//   flush             : clears every pending bit (highest priority)
//   pend              : registered pending vector, bit 0 always 0
//   pend_cnt, sb_full : number of pending registers, all writable registers pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pend,
    output logic [AW:0]      pend_cnt,
    output logic             sb_full
);

    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_clr, set, inc, dec;

    assign wr_clr = wr_en && (wr_addr != '0);
    assign set    = sb_set && (sb_addr != '0);

    // Count moves only on real transitions: a set of an idle bit, or a clear of a
    // pending bit that is not simultaneously re-set by a younger owner.
    assign inc = set && !pend_q[sb_addr];
    assign dec = wr_clr && pend_q[wr_addr] && !(set && (sb_addr == wr_addr));

    always_comb begin
        pend_d = pend_q;
        if (wr_clr) begin
            pend_d[wr_addr] = 1'b0;
        end
        // Applied after the clear so set wins on the same address.
        if (set) begin
            pend_d[sb_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
        if (flush) begin
            pend_d = '0;
        end
    end

    always_comb begin
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(inc) - CW'(dec);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend     = pend_q;
    assign pend_cnt = cnt_q;
    assign sb_full  = (cnt_q == CW'(NREGS - 1));

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: RV32I integer register file with pending-write scoreboard.
//   clk, reset                 : clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data    : synchronous write port (x0 writes discarded)
//   rd_addr / rd_data          : NUM_RD combinational read ports, packed, port 0 in LSBs
//   rd_busy                    : per read port, addressed register has a pending write
//   sb_set, sb_addr, flush     : scoreboard mark / clear-all
//   pend_cnt, sb_full          : pending-register count and all-pending flag
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_addr,
    input  logic                   flush,
    output logic [AW:0]            pend_cnt,
    output logic                   sb_full
);

    // x0 has no storage; the array starts at x1.
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [NREGS-1:0] pend;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .flush    (flush),
        .pend     (pend),
        .pend_cnt (pend_cnt),
        .sb_full  (sb_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            if (a != '0) begin
                rd_data[p*XLEN +: XLEN] = regs_q[a];
            end
            rd_busy[p] = pend[a];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; still busy if a younger owner claims it now.
            if (wr_en && (wr_addr != '0) && (wr_addr == a)) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
                rd_busy[p]              = sb_set && (sb_addr == a);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   sb_set;
    logic [AW-1:0]          sb_addr;
    logic                   flush;
    logic [AW:0]            pend_cnt;
    logic                   sb_full;

    regfile_sb u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .flush    (flush),
        .pend_cnt (pend_cnt),
        .sb_full  (sb_full)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents and the set of pending registers.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    int unsigned     checks = 0;
    int unsigned     errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic m_update();
        if (reset) begin
            m_clear();
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
            if (flush) for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] exp_d;
            logic            exp_b;
            a     = rd_addr[p*AW +: AW];
            exp_d = (a == 0) ? '0 : m_regs[a];
            exp_b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (!reset && wr_en && wr_addr != 0 && wr_addr == a) begin
                exp_d = wr_data;
                exp_b = sb_set && (sb_addr == a);
            end
`endif
            check_eq($sformatf("rd_data[%0d] x%0d", p, a), 64'(rd_data[p*XLEN +: XLEN]),
                     64'(exp_d));
            check_eq($sformatf("rd_busy[%0d] x%0d", p, a), 64'(rd_busy[p]), 64'(exp_b));
        end
        check_eq("pend_cnt", 64'(pend_cnt), 64'(m_count()));
        check_eq("sb_full", 64'(sb_full), 64'(m_count() == NREGS - 1));
    endtask

    // Inputs are driven 1 time unit after a rising edge; checked 2 units later.
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
        flush   = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_rd(0, 0);
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state across every address on both ports.
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            tick();
        end

        // x5 write, x0 write discarded.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 5'd0; wr_data = 32'h12345678;
        tick();
        idle();
        set_rd(5, 0);
        #2;
        check_eq("x5 data", 64'(rd_data[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);
        check_eq("x0 data", 64'(rd_data[XLEN +: XLEN]), 64'h0);
        tick();

        // Mark x7, then write it back.
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle();
        set_rd(7, 7);
        #2;
        check_eq("x7 busy", 64'(rd_busy[0]), 64'h1);
        check_eq("x7 pend_cnt", 64'(pend_cnt), 64'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        tick();
        idle();
        #2;
        check_eq("x7 busy cleared", 64'(rd_busy[0]), 64'h0);
        check_eq("x7 pend_cnt cleared", 64'(pend_cnt), 64'h0);
        check_eq("x7 data", 64'(rd_data[0 +: XLEN]), 64'h0000_0000_A5A5_A5A5);
        tick();

        // Set wins over clear on the same edge; flush wins over set.
        sb_set = 1'b1; sb_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        idle();
        set_rd(9, 9);
        #2;
        check_eq("x9 set-wins busy", 64'(rd_busy[0]), 64'h1);
        check_eq("x9 set-wins pend_cnt", 64'(pend_cnt), 64'h1);
        sb_set = 1'b1; sb_addr = 5'd3; flush = 1'b1;
        tick();
        idle();
        #2;
        check_eq("flush pend_cnt", 64'(pend_cnt), 64'h0);
        tick();

        // Fill the scoreboard, then reset asynchronously mid-cycle.
        for (int r = 1; r < NREGS; r++) begin
            sb_set = 1'b1; sb_addr = AW'(r);
            tick();
        end
        idle();
        set_rd(5, 9);
        #2;
        check_eq("full sb_full", 64'(sb_full), 64'h1);
        check_eq("full pend_cnt", 64'(pend_cnt), 64'd31);
        reset = 1'b1;
        #1;
        check_eq("async rst pend_cnt", 64'(pend_cnt), 64'h0);
        check_eq("async rst x5", 64'(rd_data[0 +: XLEN]), 64'h0);
        check_eq("async rst x9", 64'(rd_data[XLEN +: XLEN]), 64'h0);
        m_clear();
        @(posedge clk);
        #1;
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, (a * 7) % NREGS);
            tick();
        end
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Same-cycle read of a register being written.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        tick();
        wr_data = 32'h55;
        set_rd(0, 4);
        #2;
`ifdef REGFILE_BYPASS_EN
        check_eq("x4 same-cycle", 64'(rd_data[XLEN +: XLEN]), 64'h55);
`else
        check_eq("x4 same-cycle", 64'(rd_data[XLEN +: XLEN]), 64'h11);
`endif
        tick();
        idle();
        #2;
        check_eq("x4 next-cycle", 64'(rd_data[XLEN +: XLEN]), 64'h55);
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int ra0, ra1;
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = AW'($urandom_range(0, NREGS - 1));
            wr_data = $urandom;
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            flush   = ($urandom_range(0, 24) == 0);
            ra0     = ($urandom_range(0, 2) == 0) ? int'(wr_addr) : int'($urandom_range(0, NREGS - 1));
            ra1     = ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, NREGS - 1));
            set_rd(ra0, ra1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
